// File: rtl/mem_pkg.sv
// Shared types for the memory request path.
// One request record and the in-flight limit of the tick-tock port.
package mem_pkg;

  localparam int MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [30:0]      addr;
    logic [3:0][15:0] data;
    logic [2:0]       len;
    logic             hyper;
    logic             byte_op;
    logic             write_op;
  } mem_req_t;

endpackage

// File: rtl/memory_request_arbiter_if.sv
// Requester-side bundle of the memory request arbiter.
// master = requesters, slave = arbiter.
interface memory_request_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import mem_pkg::*;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  mem_req_t [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic                   rsp_fault;
  logic [7:0][15:0]       rsp_data;

  modport master (
    output req_valid, req,
    input  req_ready, rsp_valid,
    input  rsp_fault, rsp_data
  );

  modport slave (
    input  req_valid, req,
    output req_ready, rsp_valid,
    output rsp_fault, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid at or after ptr_i wins.
// Emits one-hot grant plus its index.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          grant_valid_o
);

  logic [IW-1:0] j;

  always_comb begin
    grant_o       = '0;
    idx_o         = '0;
    grant_valid_o = 1'b0;
    j             = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!grant_valid_o && valid_i[j]) begin
        grant_valid_o = 1'b1;
        grant_o[j]    = 1'b1;
        idx_o         = j;
      end
    end
  end

endmodule

// File: rtl/memory_request_arbiter.sv
// Shares the two-slot tick-tock port among NUM_REQ requesters
// and routes each completion back to its issuer.
module memory_request_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                  main_clk,
  input  logic                  main_reset,
  memory_request_arbiter_if.slave rq,
  output logic [1:0]            tick_tock_phase0,
  input  logic [1:0]            tick_tock_phase2_extern,
  output logic [1:0][30:0]      tt_address,
  output logic [1:0][3:0][15:0] tt_data,
  output logic [1:0][2:0]       tt_access_length,
  output logic [1:0]            tt_is_hyperfetch,
  output logic [1:0]            tt_is_byte_op,
  output logic [1:0]            tt_is_write_op,
  input  logic                  out_soft_fault,
  input  logic [7:0][15:0]      cd_access_out_full_data
);

  localparam int TW = $clog2(NUM_REQ);

  logic [1:0]           ph0_q, ph2_q, outst;
  mem_req_t [1:0]       slot_q;
  logic [1:0][TW-1:0]   tag_q;
  logic                 wr_q, rd_q;
  logic [1:0]           cnt_q;
  logic [TW-1:0]        ptr_q, gidx;
  logic [NUM_REQ-1:0]   cand, gnt;
  logic                 gvld, cmpl, live;

  assign live  = !main_reset;
  assign outst = ph0_q - tick_tock_phase2_extern;
  assign cmpl  = live && (tick_tock_phase2_extern != ph2_q);
  assign cand  = (live && outst < 2'(MAX_OUTSTANDING))
               ? rq.req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid_i       (cand),
    .ptr_i         (ptr_q),
    .grant_o       (gnt),
    .idx_o         (gidx),
    .grant_valid_o (gvld)
  );

  assign rq.req_ready = gnt;
  assign rq.rsp_valid = cmpl
                      ? (NUM_REQ'(1) << tag_q[rd_q]) : '0;
  assign rq.rsp_fault = cmpl & out_soft_fault;
  assign rq.rsp_data  = cd_access_out_full_data;

  assign tick_tock_phase0 = ph0_q;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      tt_address[s]       = slot_q[s].addr;
      tt_data[s]          = slot_q[s].data;
      tt_access_length[s] = slot_q[s].len;
      tt_is_hyperfetch[s] = slot_q[s].hyper;
      tt_is_byte_op[s]    = slot_q[s].byte_op;
      tt_is_write_op[s]   = slot_q[s].write_op;
    end
  end

  // Slots are written only at issue, so in-flight slots stay put.
  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      ph0_q  <= tick_tock_phase2_extern;
      ph2_q  <= tick_tock_phase2_extern;
      slot_q <= '0;
      tag_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= '0;
    end else begin
      ph2_q <= tick_tock_phase2_extern;
      if (gvld) begin
        slot_q[ph0_q[0]] <= rq.req[gidx];
        tag_q[wr_q]      <= gidx;
        wr_q             <= !wr_q;
        ph0_q            <= ph0_q + 2'd1;
        ptr_q <= (gidx == TW'(NUM_REQ - 1))
               ? '0 : gidx + TW'(1);
      end
      if (cmpl)
        rd_q <= !rd_q;
      cnt_q <= cnt_q + {1'b0, gvld} - {1'b0, cmpl};
    end
  end

  a_no_underflow: assert property (
    @(posedge main_clk) disable iff (main_reset)
    cmpl |-> cnt_q != 2'd0);

  a_max_outst: assert property (
    @(posedge main_clk) disable iff (main_reset)
    outst <= 2'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Randomized bench for memory_request_arbiter against a
// queue-based model of issue order, slots and completions.
module tb_memory_request_arbiter;
  import mem_pkg::*;

  localparam int N = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            ph0;
  logic [1:0]            ph2x;
  logic [1:0][30:0]      tt_address;
  logic [1:0][3:0][15:0] tt_data;
  logic [1:0][2:0]       tt_access_length;
  logic [1:0]            tt_is_hyperfetch;
  logic [1:0]            tt_is_byte_op;
  logic [1:0]            tt_is_write_op;
  logic                  sf;
  logic [7:0][15:0]      cd;

  memory_request_arbiter_if #(.NUM_REQ(N)) bus ();

  memory_request_arbiter #(.NUM_REQ(N)) dut (
    .main_clk                (clk),
    .main_reset              (rst),
    .rq                      (bus),
    .tick_tock_phase0        (ph0),
    .tick_tock_phase2_extern (ph2x),
    .tt_address              (tt_address),
    .tt_data                 (tt_data),
    .tt_access_length        (tt_access_length),
    .tt_is_hyperfetch        (tt_is_hyperfetch),
    .tt_is_byte_op           (tt_is_byte_op),
    .tt_is_write_op          (tt_is_write_op),
    .out_soft_fault          (sf),
    .cd_access_out_full_data (cd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       who;
    logic     slot;
    mem_req_t r;
  } fl_t;

  fl_t        fl[$];
  mem_req_t   cur[N];
  int         n_vec = 0;
  int         n_err = 0;
  int         rr_m;
  logic [1:0] ph0_m, ph2_m;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic mem_req_t rnd_req();
    mem_req_t r;
    r.addr     = 31'($urandom);
    for (int i = 0; i < 4; i++) r.data[i] = 16'($urandom);
    r.len      = 3'($urandom);
    r.hyper    = 1'($urandom);
    r.byte_op  = 1'($urandom);
    r.write_op = 1'($urandom);
    return r;
  endfunction

  function automatic mem_req_t slot_at(input logic s);
    mem_req_t r;
    r.addr     = tt_address[s];
    r.data     = tt_data[s];
    r.len      = tt_access_length[s];
    r.hyper    = tt_is_hyperfetch[s];
    r.byte_op  = tt_is_byte_op[s];
    r.write_op = tt_is_write_op[s];
    return r;
  endfunction

  function automatic logic [7:0][15:0] mem_word(
      input logic [30:0] a);
    logic [7:0][15:0] w;
    for (int i = 0; i < 8; i++)
      w[i] = a[15:0] ^ (16'h1357 * 16'(i + 1));
    return w;
  endfunction

  task automatic reset_dut(input logic [1:0] ph);
    rst           = 1'b1;
    ph2x          = ph;
    bus.req_valid = '1;
    sf            = 1'b1;
    cd            = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(bus.req_ready), 128'(0));
    chk("rst_rsp", 128'(bus.rsp_valid), 128'(0));
    chk("rst_fault", 128'(bus.rsp_fault), 128'(0));
    chk("rst_phase0", 128'(ph0), 128'(ph));
    chk("rst_slot0", 128'(slot_at(1'b0)), 128'(0));
    chk("rst_slot1", 128'(slot_at(1'b1)), 128'(0));
    rst           = 1'b0;
    bus.req_valid = '0;
    sf            = 1'b0;
    fl.delete();
    rr_m  = 0;
    ph0_m = ph;
    ph2_m = ph;
  endtask

  task automatic cycle(input logic [N-1:0] v,
                       input bit want_c,
                       input bit flt);
    bit           do_c;
    logic [1:0]   outst;
    int           win;
    logic [N-1:0] exp_rdy, exp_rsp;
    fl_t          e;
    @(posedge clk);
    #1;
    chk("phase0", 128'(ph0), 128'(ph0_m));
    foreach (fl[i])
      chk($sformatf("slot%0d", fl[i].slot),
          128'(slot_at(fl[i].slot)), 128'(fl[i].r));
    do_c = want_c && fl.size() > 0;
    if (do_c) ph2_m = ph2_m + 2'd1;
    ph2x = ph2_m;
    sf   = flt;
    if (do_c) cd = mem_word(fl[0].r.addr);
    else      cd = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = v;
    for (int r = 0; r < N; r++) bus.req[r] = cur[r];
    #1;
    outst   = ph0_m - ph2_m;
    exp_rdy = '0;
    win     = -1;
    if (outst < 2'd2)
      for (int k = 0; k < N; k++)
        if (win < 0 && ((v >> ((rr_m + k) % N)) & 1) != 0)
          win = (rr_m + k) % N;
    if (win >= 0) exp_rdy = N'(1) << win;
    chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
    exp_rsp = do_c ? (N'(1) << fl[0].who) : '0;
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rsp));
    chk("rsp_fault", 128'(bus.rsp_fault), 128'(do_c && flt));
    if (do_c && !fl[0].r.write_op)
      chk("rsp_data", 128'(bus.rsp_data),
          128'(mem_word(fl[0].r.addr)));
    if (do_c) void'(fl.pop_front());
    if (win >= 0) begin
      e.who  = win;
      e.slot = ph0_m[0];
      e.r    = cur[win];
      fl.push_back(e);
      ph0_m = ph0_m + 2'd1;
      rr_m  = (win + 1) % N;
    end
  endtask

  int stall;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req       = '0;
    ph2x          = 2'd0;
    sf            = 1'b0;
    cd            = '0;
    for (int r = 0; r < N; r++) cur[r] = rnd_req();
    reset_dut(2'd0);

    cur[1]          = '0;
    cur[1].addr     = 31'h0000_1230;
    cur[1].write_op = 1'b0;
    cycle(3'b010, 0, 0);
    cycle(3'b000, 1, 0);
    cycle(3'b000, 0, 0);

    for (int r = 0; r < N; r++) cur[r] = rnd_req();
    repeat (2) cycle(3'b111, 0, 0);
    repeat (6) cycle(3'b111, 1, 0);

    repeat (40) cycle(3'b111, 0, 0);
    repeat (3) cycle(3'b000, 1, 0);

    cur[2]          = rnd_req();
    cur[2].write_op = 1'b1;
    cycle(3'b100, 0, 0);
    cycle(3'b000, 1, 1);
    cycle(3'b000, 0, 1);

    repeat (10) begin
      cur[0] = rnd_req();
      cycle(3'b001, 0, 0);
      cycle(3'b000, 1, 0);
    end

    reset_dut(2'd3);

    stall = 0;
    repeat (600) begin
      for (int r = 0; r < N; r++) cur[r] = rnd_req();
      if (stall == 0 && $urandom_range(0, 49) == 0)
        stall = $urandom_range(5, 20);
      if (stall > 0) stall--;
      cycle(3'($urandom),
            stall == 0 && $urandom_range(0, 3) != 0,
            1'($urandom));
    end
    repeat (4) cycle(3'b000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
